// File: rtl/cp0_multilane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cp0_multilane : commit-stage CP0 (timer, interrupts, exceptions, ERET)    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module cp0_multilane #(
  parameter int          LANES    = 2,
  parameter int          TICK_DIV = 2,
  parameter logic [31:0] EXC_VEC  = 32'hBFC00380
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [5:0]                           ext_int,
  input  logic [LANES-1:0]                     commit_valid,
  input  logic [LANES-1:0]                     exc_valid,
  input  logic [5*LANES-1:0]                   exc_code,
  input  logic [LANES-1:0]                     exc_bd,
  input  logic [32*LANES-1:0]                  exc_pc,
  input  logic [32*LANES-1:0]                  exc_badvaddr,
  input  logic [LANES-1:0]                     is_eret,
  input  logic                                 mtc0_we,
  input  logic [((LANES>1)?$clog2(LANES):1)-1:0] mtc0_lane,
  input  logic [4:0]                           mtc0_addr,
  input  logic [31:0]                          mtc0_wdata,
  input  logic [4:0]                           mfc0_addr,
  output logic [31:0]                          mfc0_rdata,
  output logic                                 flush,
  output logic [31:0]                          flush_pc,
  output logic [LANES-1:0]                     kill_mask,
  output logic [31:0]                          epc_o
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;

  logic [31:0]   badvaddr, count, compare, epc;
  logic [DW-1:0] div;
  logic [7:0]    im;
  logic          exl, ie;
  logic          bd, ti;
  logic [5:0]    ip_hw;
  logic [1:0]    ip_sw;
  logic [4:0]    cause_code;

  logic [7:0]    ip;
  logic          int_req;

  // Arbitration results
  logic          found, take_exc, take_eret;
  logic [LW-1:0] win;
  logic [31:0]   win_pc, win_bva, eret_pc;
  logic [4:0]    win_code;
  logic          win_bd;
  logic          mtc0_ok;

  assign ip      = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
  assign int_req = (|(ip & im)) & ie & ~exl;

  always_comb begin
    found     = 1'b0;
    take_exc  = 1'b0;
    take_eret = 1'b0;
    win       = '0;
    win_pc    = '0;
    win_bva   = '0;
    win_code  = '0;
    win_bd    = 1'b0;
    if (int_req && commit_valid[0]) begin
      found    = 1'b1;
      take_exc = 1'b1;
      win_pc   = exc_pc[31:0];
      win_bd   = exc_bd[0];
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (!found && commit_valid[i] && (exc_valid[i] || is_eret[i])) begin
          found     = 1'b1;
          win       = LW'(i);
          take_exc  = exc_valid[i];
          take_eret = ~exc_valid[i];
          win_pc    = exc_pc[32*i +: 32];
          win_bva   = exc_badvaddr[32*i +: 32];
          win_code  = exc_code[5*i +: 5];
          win_bd    = exc_bd[i];
        end
      end
    end
  end

  // A surviving MTC0 in the flush cycle is necessarily from an older lane.
  assign mtc0_ok = mtc0_we & ~(found & (mtc0_lane >= win));
  assign eret_pc = (mtc0_ok && mtc0_addr == A_EPC) ? mtc0_wdata : epc;

  always_comb begin
    flush     = found;
    flush_pc  = '0;
    kill_mask = '0;
    if (take_exc)
      flush_pc = EXC_VEC;
    else if (take_eret)
      flush_pc = eret_pc;
    for (int j = 0; j < LANES; j++)
      kill_mask[j] = found & (LW'(j) >= win);
  end

  always_comb begin
    mfc0_rdata = '0;
    case (mfc0_addr)
      A_BADVADDR: mfc0_rdata = badvaddr;
      A_COUNT:    mfc0_rdata = count;
      A_COMPARE:  mfc0_rdata = compare;
      A_STATUS:   mfc0_rdata = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
      A_CAUSE:    mfc0_rdata = {bd, ti, 14'b0, ip, 1'b0, cause_code, 2'b0};
      A_EPC:      mfc0_rdata = epc;
      default:    mfc0_rdata = '0;
    endcase
  end

  assign epc_o = epc;

  // MTC0 effects first; exception/ERET assignments later override shared fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr   <= '0;
      count      <= '0;
      compare    <= '0;
      epc        <= '0;
      div        <= '0;
      im         <= '0;
      exl        <= 1'b0;
      ie         <= 1'b0;
      bd         <= 1'b0;
      ti         <= 1'b0;
      ip_hw      <= '0;
      ip_sw      <= '0;
      cause_code <= '0;
    end else begin
      ip_hw <= ext_int;

      if (mtc0_ok && mtc0_addr == A_COUNT) begin
        count <= mtc0_wdata;
        div   <= '0;
      end else if (div == DIV_LAST) begin
        count <= count + 32'd1;
        div   <= '0;
      end else begin
        div <= div + DW'(1);
      end

      if (mtc0_ok && mtc0_addr == A_COMPARE)
        ti <= 1'b0;
      else if (count == compare)
        ti <= 1'b1;

      if (mtc0_ok) begin
        case (mtc0_addr)
          A_COMPARE: compare <= mtc0_wdata;
          A_STATUS: begin
            im  <= mtc0_wdata[15:8];
            exl <= mtc0_wdata[1];
            ie  <= mtc0_wdata[0];
          end
          A_CAUSE:   ip_sw <= mtc0_wdata[9:8];
          A_EPC:     epc   <= mtc0_wdata;
          default: ;
        endcase
      end

      if (take_exc) begin
        if (!exl) begin
          epc <= win_bd ? win_pc - 32'd4 : win_pc;
          bd  <= win_bd;
        end
        exl        <= 1'b1;
        cause_code <= win_code;
        if (win_code == 5'd4 || win_code == 5'd5)
          badvaddr <= win_bva;
      end else if (take_eret) begin
        exl <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cp0_multilane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cp0_multilane : directed self-checking bench for cp0_multilane         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_cp0_multilane;

  localparam int LANES = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    ext_int;
  logic [1:0]    commit_valid, exc_valid, exc_bd, is_eret;
  logic [9:0]    exc_code;
  logic [63:0]   exc_pc, exc_badvaddr;
  logic          mtc0_we;
  logic [0:0]    mtc0_lane;
  logic [4:0]    mtc0_addr, mfc0_addr;
  logic [31:0]   mtc0_wdata, mfc0_rdata, flush_pc, epc_o;
  logic          flush;
  logic [1:0]    kill_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cp0_multilane #(.LANES(LANES), .TICK_DIV(2), .EXC_VEC(32'hBFC00380)) dut (
    .clk(clk), .rst(rst), .ext_int(ext_int),
    .commit_valid(commit_valid), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_bd(exc_bd), .exc_pc(exc_pc), .exc_badvaddr(exc_badvaddr),
    .is_eret(is_eret), .mtc0_we(mtc0_we), .mtc0_lane(mtc0_lane),
    .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata), .mfc0_addr(mfc0_addr),
    .mfc0_rdata(mfc0_rdata), .flush(flush), .flush_pc(flush_pc),
    .kill_mask(kill_mask), .epc_o(epc_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    mfc0_addr = a;
    #1;
    check(tag, mfc0_rdata, exp);
  endtask

  task automatic idle();
    commit_valid = '0; exc_valid = '0; exc_bd = '0; is_eret = '0;
    exc_code = '0; exc_pc = '0; exc_badvaddr = '0;
    mtc0_we = 1'b0; mtc0_lane = '0; mtc0_addr = '0; mtc0_wdata = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d, input logic l);
    mtc0_we = 1'b1; mtc0_addr = a; mtc0_wdata = d; mtc0_lane = l;
  endtask

  task automatic lane_exc(input int l, input logic [4:0] code, input logic bdv,
                          input logic [31:0] pc, input logic [31:0] bva);
    commit_valid[l] = 1'b1;
    exc_valid[l]    = 1'b1;
    exc_bd[l]       = bdv;
    exc_code[5*l +: 5]      = code;
    exc_pc[32*l +: 32]      = pc;
    exc_badvaddr[32*l +: 32] = bva;
  endtask

  initial begin
    rst = 1'b1; ext_int = '0; mfc0_addr = '0;
    idle();
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_kill", {30'b0, kill_mask}, 32'h0);
    check("rst_flush_pc", flush_pc, 32'h0);
    rd("rst_status", 5'd12, 32'h00400000);
    rd("rst_count", 5'd9, 32'h0);
    repeat (10) step();
    rd("count_after_10", 5'd9, 32'd5);
    // Count==Compare==0 right after reset sets TI, reflected in IP7 too.
    rd("cause_boot_ti", 5'd13, 32'h40008000);

    // Timer interrupt
    mtc0(5'd11, 32'd3, 1'b0); step(); idle();
    mtc0(5'd9, 32'd0, 1'b0); step(); idle();
    mtc0(5'd12, 32'h00408001, 1'b0); step(); idle();
    repeat (5) step();
    rd("count_eq_compare", 5'd9, 32'd3);
    rd("cause_before_ti", 5'd13, 32'h0);
    commit_valid = 2'b01;
    #1;
    check("no_int_flush", {31'b0, flush}, 32'h0);
    step(); idle();
    rd("cause_ti_set", 5'd13, 32'h40008000);
    commit_valid = 2'b01; exc_pc[31:0] = 32'h80000200;
    #1;
    check("int_flush", {31'b0, flush}, 32'h1);
    check("int_flush_pc", flush_pc, 32'hBFC00380);
    check("int_kill", {30'b0, kill_mask}, 32'h3);
    step(); idle();
    rd("int_epc", 5'd14, 32'h80000200);
    check("int_epc_o", epc_o, 32'h80000200);
    rd("int_status", 5'd12, 32'h00408003);
    rd("int_cause", 5'd13, 32'h40008000);
    mtc0(5'd11, 32'h100, 1'b0); step(); idle();
    rd("ti_cleared", 5'd13, 32'h0);
    mtc0(5'd12, 32'h0, 1'b0); step(); idle();
    rd("status_cleared", 5'd12, 32'h00400000);

    // Lane arbitration
    commit_valid = 2'b11;
    lane_exc(1, 5'd12, 1'b0, 32'h80000304, 32'h0);
    #1;
    check("l1_flush", {31'b0, flush}, 32'h1);
    check("l1_kill", {30'b0, kill_mask}, 32'h2);
    check("l1_flush_pc", flush_pc, 32'hBFC00380);
    step(); idle();
    rd("l1_epc", 5'd14, 32'h80000304);
    rd("l1_cause", 5'd13, 32'h00000030);
    rd("l1_badvaddr", 5'd8, 32'h0);
    rd("l1_status", 5'd12, 32'h00400002);
    mtc0(5'd12, 32'h0, 1'b0); step(); idle();
    lane_exc(0, 5'd10, 1'b0, 32'h80000400, 32'h0);
    lane_exc(1, 5'd12, 1'b0, 32'h80000304, 32'h0);
    #1;
    check("both_kill", {30'b0, kill_mask}, 32'h3);
    step(); idle();
    rd("both_epc", 5'd14, 32'h80000400);
    rd("both_cause", 5'd13, 32'h00000028);
    mtc0(5'd12, 32'h0, 1'b0); step(); idle();

    // Delay slot, then nested exception with EXL=1
    lane_exc(0, 5'd4, 1'b1, 32'h80000104, 32'h00001001);
    step(); idle();
    rd("bd_epc", 5'd14, 32'h80000100);
    rd("bd_cause", 5'd13, 32'h80000010);
    rd("bd_badvaddr", 5'd8, 32'h00001001);
    lane_exc(0, 5'd5, 1'b0, 32'h80000500, 32'h00002002);
    step(); idle();
    rd("nest_epc", 5'd14, 32'h80000100);
    rd("nest_cause", 5'd13, 32'h80000014);
    rd("nest_badvaddr", 5'd8, 32'h00002002);

    // ERET with EPC forwarded from an older-lane MTC0
    mtc0(5'd14, 32'h80001000, 1'b0);
    commit_valid = 2'b11; is_eret = 2'b10;
    #1;
    check("eret_flush", {31'b0, flush}, 32'h1);
    check("eret_flush_pc", flush_pc, 32'h80001000);
    check("eret_kill", {30'b0, kill_mask}, 32'h2);
    step(); idle();
    rd("eret_status", 5'd12, 32'h00400000);
    rd("eret_epc", 5'd14, 32'h80001000);

    // MTC0 suppression: younger lane suppressed, older lane applied
    mtc0(5'd12, 32'h0000FF01, 1'b1);
    commit_valid = 2'b11;
    lane_exc(0, 5'd10, 1'b0, 32'h80000600, 32'h0);
    #1;
    check("sup_kill", {30'b0, kill_mask}, 32'h3);
    step(); idle();
    rd("sup_status", 5'd12, 32'h00400002);
    rd("sup_epc", 5'd14, 32'h80000600);
    rd("sup_cause", 5'd13, 32'h00000028);
    mtc0(5'd11, 32'h1234, 1'b0);
    commit_valid = 2'b11;
    lane_exc(1, 5'd12, 1'b0, 32'h80000700, 32'h0);
    #1;
    check("old_mtc0_kill", {30'b0, kill_mask}, 32'h2);
    step(); idle();
    rd("old_mtc0_compare", 5'd11, 32'h00001234);
    rd("old_mtc0_epc", 5'd14, 32'h80000600);
    rd("old_mtc0_cause", 5'd13, 32'h00000030);

    // Hardware IP sampling and Cause write mask
    ext_int = 6'b100001;
    mtc0(5'd13, 32'hFFFFFFFF, 1'b0);
    step(); idle();
    ext_int = '0;
    rd("cause_ip", 5'd13, 32'h00008730);
    rd("unmapped", 5'd3, 32'h0);

    // Count wrap
    mtc0(5'd9, 32'hFFFFFFFF, 1'b0); step(); idle();
    rd("wrap_load", 5'd9, 32'hFFFFFFFF);
    step();
    rd("wrap_hold", 5'd9, 32'hFFFFFFFF);
    step();
    rd("wrap_zero", 5'd9, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cp0_multilane.md
Name: cp0_multilane

Overview:
- Parametrised CP0 coprocessor for a LANES-wide in-order issue pipeline. Sits at the commit stage.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC; provides the MTC0 write port and the MFC0 read port.
- Samples 6 hardware interrupt lines and raises the timer interrupt.
- Arbitrates exceptions, interrupts and ERET across lanes, then issues one flush with a redirect PC and a per-lane kill mask.

Parameters:
- LANES, 2, number of commit lanes; lane 0 is the oldest.
- TICK_DIV, 2, clk cycles per Count increment (must be >= 1).
- EXC_VEC, 32'hBFC00380, exception entry vector.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ext_int  in  6  hardware interrupt lines, level-sensitive.
- commit_valid  in  LANES  lane holds a committing instruction.
- exc_valid  in  LANES  lane raises an exception.
- exc_code  in  5*LANES  ExcCode per lane (lane i at [5i+4:5i]).
- exc_bd  in  LANES  lane instruction is in a delay slot.
- exc_pc  in  32*LANES  lane PC.
- exc_badvaddr  in  32*LANES  faulting address per lane.
- is_eret  in  LANES  lane commits ERET.
- mtc0_we  in  1  MTC0 write strobe.
- mtc0_lane  in  log2(LANES) (min 1)  lane issuing the MTC0.
- mtc0_addr  in  5  register number.
- mtc0_wdata  in  32  write data.
- mfc0_addr  in  5  read register number.
- mfc0_rdata  out  32  combinational read data.
- flush  out  1  redirect pipeline.
- flush_pc  out  32  redirect target.
- kill_mask  out  LANES  lanes to squash (winner lane and all younger lanes).
- epc_o  out  32  current EPC.

Behaviour:
- Register addresses:
  - 8 BadVAddr: read-only.
  - 9 Count.
  - 11 Compare.
  - 12 Status: bit22 BEV fixed 1; writable bits IM[15:8], EXL[1], IE[0].
  - 13 Cause: BD[31], TI[30], IP[15:8], ExcCode[6:2]; only IP[9:8] are MTC0-writable.
  - 14 EPC.
  - Any other address reads 0 and ignores writes. Non-writable bits read 0 unless stated.
- Reset: Status=32'h00400000; all other registers 0; tick divider 0; flush=0, kill_mask=0, flush_pc=0.
- Count: increments by 1 each time the divider reaches TICK_DIV-1, then the divider returns to 0. An MTC0 to Count loads the value and clears the divider. Count wraps 32'hFFFFFFFF -> 0.
- Timer: TI is set on the cycle after registered Count==Compare. Any MTC0 to Compare clears TI. Clear wins over set in the same cycle.
- Cause IP[7:2]: registered from ext_int each cycle. IP[7] = ext_int[5] | TI.
- Interrupt request: int_req = |(IP & IM) & IE & ~EXL.
- Arbitration, combinational in the same cycle; priority:
  1. Interrupt, if int_req and commit_valid[0]: winner lane 0, ExcCode 0.
  2. Otherwise, the lowest lane i with commit_valid[i] & (exc_valid[i] | is_eret[i]).
  - If both are set on one lane, exc_valid beats is_eret.
- Exception taken (interrupt or exc_valid):
  - If EXL==0: EPC <= bd ? pc-4 : pc; BD <= bd. If EXL==1: EPC and BD are unchanged.
  - Always: EXL <= 1; ExcCode <= code.
  - BadVAddr <= lane exc_badvaddr only for codes 4 and 5.
  - flush=1, flush_pc=EXC_VEC.
- ERET winner: EXL <= 0; flush=1; flush_pc = EPC, forwarded from an older-lane MTC0 to EPC in the same cycle.
- kill_mask bit j = flush & (j >= winner lane).
- MTC0 is suppressed when flush and mtc0_lane >= winner lane. Otherwise the write applies.
- When an exception/ERET update and an MTC0 both hit the same field in one cycle, the exception/ERET update wins.
- flush, flush_pc and kill_mask are combinational, valid the same cycle; register updates are visible from the next cycle.
- mfc0_rdata returns the pre-update register values.

Test Plan:
- Reset then Count: after rst, read Status -> 32'h00400000. With TICK_DIV=2, after 10 cycles Count=5.
- Timer interrupt: MTC0 Compare=3, Status=32'h00408001. When Count reaches 3, TI is set next cycle. With commit_valid[0]=1: flush=1, flush_pc=BFC00380, ExcCode=0, EPC=lane0 pc. A subsequent MTC0 Compare clears TI.
- Lane arbitration: lane1 exc_valid code 12, lane0 clean: winner lane1, kill_mask=2'b10. Both lanes excepting: lane0 wins, kill_mask=2'b11.
- Delay slot and nesting:
  - exc_bd=1, pc=0x80000104, code 4, badvaddr=0x1001 -> EPC=0x80000100, BD=1, BadVAddr=0x1001.
  - A second exception with EXL=1 leaves EPC unchanged.
- ERET forwarding: lane0 MTC0 EPC=0x80001000, lane1 ERET in the same cycle -> flush_pc=0x80001000, EXL=0 next cycle.
- MTC0 suppression: lane0 exception plus lane1 MTC0 Status -> Status keeps only the exception effects. Lane1 exception plus lane0 MTC0 Compare -> Compare is written.
